// File: rtl/hicore_icb_split2.sv
// -----------------------------------------------------------------------------
// hicore_icb_split2
//   1-to-2 ICB splitter placed in front of the default (error) slave. Each
//   master command goes either to the decoded region port (o0) or, on an
//   address miss, to the default port (od). A small FIFO records which port
//   took each accepted command. Responses are then returned to the master
//   strictly in issue order.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   i_icb_cmd_*              master command: valid/ready, addr, read, wdata, wmask
//   i_icb_rsp_*              master response: valid/ready, err, rdata
//   o0_icb_cmd_*, o0_icb_rsp_*   region-0 slave side
//   od_icb_cmd_*, od_icb_rsp_*   default (error) slave side
// -----------------------------------------------------------------------------
module hicore_icb_split2 #(
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter logic [AW-1:0] O0_BASE = 32'h1000_0000,
    parameter logic [AW-1:0] O0_MASK = 32'hF000_0000,
    parameter int          OUTS_N  = 2
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i_icb_cmd_valid,
    output logic            i_icb_cmd_ready,
    input  logic [AW-1:0]   i_icb_cmd_addr,
    input  logic            i_icb_cmd_read,
    input  logic [DW-1:0]   i_icb_cmd_wdata,
    input  logic [DW/8-1:0] i_icb_cmd_wmask,
    output logic            i_icb_rsp_valid,
    input  logic            i_icb_rsp_ready,
    output logic            i_icb_rsp_err,
    output logic [DW-1:0]   i_icb_rsp_rdata,

    output logic            o0_icb_cmd_valid,
    input  logic            o0_icb_cmd_ready,
    output logic [AW-1:0]   o0_icb_cmd_addr,
    output logic            o0_icb_cmd_read,
    output logic [DW-1:0]   o0_icb_cmd_wdata,
    output logic [DW/8-1:0] o0_icb_cmd_wmask,
    input  logic            o0_icb_rsp_valid,
    output logic            o0_icb_rsp_ready,
    input  logic            o0_icb_rsp_err,
    input  logic [DW-1:0]   o0_icb_rsp_rdata,

    output logic            od_icb_cmd_valid,
    input  logic            od_icb_cmd_ready,
    output logic [AW-1:0]   od_icb_cmd_addr,
    output logic            od_icb_cmd_read,
    output logic [DW-1:0]   od_icb_cmd_wdata,
    output logic [DW/8-1:0] od_icb_cmd_wmask,
    input  logic            od_icb_rsp_valid,
    output logic            od_icb_rsp_ready,
    input  logic            od_icb_rsp_err,
    input  logic [DW-1:0]   od_icb_rsp_rdata
);

    // A depth-1 FIFO still gets a 1-bit pointer; it simply never leaves 0.
    localparam int PTR_W = (OUTS_N > 1) ? $clog2(OUTS_N) : 1;
    localparam int CNT_W = $clog2(OUTS_N + 1);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    // Port id per outstanding command: 0 = o0, 1 = od.
    logic             fifo_port [OUTS_N];

    logic hit;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_port;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUTS_N - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // ---------------- command path ----------------
    assign hit   = (i_icb_cmd_addr & O0_MASK) == O0_BASE;
    assign full  = (count == CNT_W'(OUTS_N));
    assign empty = (count == '0);

    assign o0_icb_cmd_addr  = i_icb_cmd_addr;
    assign o0_icb_cmd_read  = i_icb_cmd_read;
    assign o0_icb_cmd_wdata = i_icb_cmd_wdata;
    assign o0_icb_cmd_wmask = i_icb_cmd_wmask;
    assign od_icb_cmd_addr  = i_icb_cmd_addr;
    assign od_icb_cmd_read  = i_icb_cmd_read;
    assign od_icb_cmd_wdata = i_icb_cmd_wdata;
    assign od_icb_cmd_wmask = i_icb_cmd_wmask;

    assign o0_icb_cmd_valid = i_icb_cmd_valid &  hit & ~full;
    assign od_icb_cmd_valid = i_icb_cmd_valid & ~hit & ~full;

    // Gated by the registered full only: a same-cycle pop never frees a slot
    // for the command path, so there is no response-to-command timing path.
    assign i_icb_cmd_ready = ~full & (hit ? o0_icb_cmd_ready : od_icb_cmd_ready);

    assign push = i_icb_cmd_valid & i_icb_cmd_ready;

    // ---------------- response path ----------------
    assign head_port = fifo_port[rptr];

    assign i_icb_rsp_valid  = ~empty & (head_port ? od_icb_rsp_valid : o0_icb_rsp_valid);
    assign i_icb_rsp_err    = head_port ? od_icb_rsp_err   : o0_icb_rsp_err;
    assign i_icb_rsp_rdata  = head_port ? od_icb_rsp_rdata : o0_icb_rsp_rdata;

    // The non-head port is held off so an early response cannot overtake.
    assign o0_icb_rsp_ready = ~empty & ~head_port & i_icb_rsp_ready;
    assign od_icb_rsp_ready = ~empty &  head_port & i_icb_rsp_ready;

    assign pop = i_icb_rsp_valid & i_icb_rsp_ready;

    // ---------------- outstanding FIFO ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; entries are only read once written after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_port[wptr] <= ~hit;
        end
    end

endmodule

// File: tb/tb_hicore_icb_split2.sv
module tb_hicore_icb_split2;

    localparam int OUTS_N = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        i_icb_cmd_valid, i_icb_cmd_ready, i_icb_cmd_read;
    logic [31:0] i_icb_cmd_addr, i_icb_cmd_wdata;
    logic [3:0]  i_icb_cmd_wmask;
    logic        i_icb_rsp_valid, i_icb_rsp_ready, i_icb_rsp_err;
    logic [31:0] i_icb_rsp_rdata;

    logic        o0_icb_cmd_valid, o0_icb_cmd_ready, o0_icb_cmd_read;
    logic [31:0] o0_icb_cmd_addr, o0_icb_cmd_wdata;
    logic [3:0]  o0_icb_cmd_wmask;
    logic        o0_icb_rsp_valid, o0_icb_rsp_ready, o0_icb_rsp_err;
    logic [31:0] o0_icb_rsp_rdata;

    logic        od_icb_cmd_valid, od_icb_cmd_ready, od_icb_cmd_read;
    logic [31:0] od_icb_cmd_addr, od_icb_cmd_wdata;
    logic [3:0]  od_icb_cmd_wmask;
    logic        od_icb_rsp_valid, od_icb_rsp_ready, od_icb_rsp_err;
    logic [31:0] od_icb_rsp_rdata;

    hicore_icb_split2 #(.AW(32), .DW(32), .O0_BASE(32'h1000_0000),
                        .O0_MASK(32'hF000_0000), .OUTS_N(OUTS_N)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_icb_cmd_valid(i_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
        .i_icb_cmd_addr(i_icb_cmd_addr), .i_icb_cmd_read(i_icb_cmd_read),
        .i_icb_cmd_wdata(i_icb_cmd_wdata), .i_icb_cmd_wmask(i_icb_cmd_wmask),
        .i_icb_rsp_valid(i_icb_rsp_valid), .i_icb_rsp_ready(i_icb_rsp_ready),
        .i_icb_rsp_err(i_icb_rsp_err), .i_icb_rsp_rdata(i_icb_rsp_rdata),
        .o0_icb_cmd_valid(o0_icb_cmd_valid), .o0_icb_cmd_ready(o0_icb_cmd_ready),
        .o0_icb_cmd_addr(o0_icb_cmd_addr), .o0_icb_cmd_read(o0_icb_cmd_read),
        .o0_icb_cmd_wdata(o0_icb_cmd_wdata), .o0_icb_cmd_wmask(o0_icb_cmd_wmask),
        .o0_icb_rsp_valid(o0_icb_rsp_valid), .o0_icb_rsp_ready(o0_icb_rsp_ready),
        .o0_icb_rsp_err(o0_icb_rsp_err), .o0_icb_rsp_rdata(o0_icb_rsp_rdata),
        .od_icb_cmd_valid(od_icb_cmd_valid), .od_icb_cmd_ready(od_icb_cmd_ready),
        .od_icb_cmd_addr(od_icb_cmd_addr), .od_icb_cmd_read(od_icb_cmd_read),
        .od_icb_cmd_wdata(od_icb_cmd_wdata), .od_icb_cmd_wmask(od_icb_cmd_wmask),
        .od_icb_rsp_valid(od_icb_rsp_valid), .od_icb_rsp_ready(od_icb_rsp_ready),
        .od_icb_rsp_err(od_icb_rsp_err), .od_icb_rsp_rdata(od_icb_rsp_rdata)
    );

    // Reference: ordered list of responses the master is owed, plus one
    // command queue per slave model.
    typedef struct {
        bit          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        ref_q[$];
    logic [31:0] s0_q[$];
    logic [31:0] sd_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic        last_o0_cv, last_od_cv, last_cmd_ready, last_rv, last_err, last_od_rr;
    logic [31:0] last_rdata;
    int          last_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o0_data(input logic [31:0] a);
        return a ^ 32'hCEAD_BEEB;
    endfunction

    function automatic logic [31:0] od_data(input logic [31:0] a);
        return ~a;
    endfunction

    function automatic bit is_hit(input logic [31:0] a);
        return a[31:28] == 4'h1;
    endfunction

    function automatic logic pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    // amode: 0 mixed, 1 region-0 hit, 2 miss, 3 fixed address fa
    function automatic logic [31:0] gen_addr(input int amode, input logic [31:0] fa);
        logic [31:0] r;
        logic [3:0]  top;
        r = $urandom;
        if (amode == 3) return fa;
        if (amode == 1 || (amode == 0 && pct(50))) return {4'h1, r[27:0]};
        top = 4'($urandom_range(0, 14));
        if (top >= 4'd1) top = top + 4'd1;
        return {top, r[27:0]};
    endfunction

    task automatic step(input int c_pct, input int mr_pct, input int s0r_pct,
                        input int sdr_pct, input int s0v_pct, input int sdv_pct,
                        input int amode, input logic [31:0] fa, input logic rd);
        bit   hit, full, head, empty;
        logic exp_rv;
        exp_t e;
        logic [31:0] r;
        @(negedge clk);
        i_icb_cmd_valid  = pct(c_pct);
        i_icb_cmd_addr   = gen_addr(amode, fa);
        i_icb_cmd_read   = (amode == 3) ? rd : 1'($urandom_range(0, 1));
        i_icb_cmd_wdata  = $urandom;
        i_icb_cmd_wmask  = 4'($urandom_range(0, 15));
        i_icb_rsp_ready  = pct(mr_pct);
        o0_icb_cmd_ready = pct(s0r_pct);
        od_icb_cmd_ready = pct(sdr_pct);
        r = $urandom;
        o0_icb_rsp_err = 1'b0;
        od_icb_rsp_err = 1'b1;
        if (s0_q.size() > 0) begin
            o0_icb_rsp_valid = pct(s0v_pct);
            o0_icb_rsp_rdata = o0_data(s0_q[0]);
        end else begin
            o0_icb_rsp_valid = (s0v_pct > 0) && pct(10);
            o0_icb_rsp_rdata = r;
        end
        if (sd_q.size() > 0) begin
            od_icb_rsp_valid = pct(sdv_pct);
            od_icb_rsp_rdata = od_data(sd_q[0]);
        end else begin
            od_icb_rsp_valid = (sdv_pct > 0) && pct(10);
            od_icb_rsp_rdata = ~r;
        end
        #1;
        hit   = is_hit(i_icb_cmd_addr);
        full  = (ref_q.size() == OUTS_N);
        empty = (ref_q.size() == 0);
        check("o0_cmd_valid", o0_icb_cmd_valid, i_icb_cmd_valid & hit & ~full);
        check("od_cmd_valid", od_icb_cmd_valid, i_icb_cmd_valid & ~hit & ~full);
        check("cmd_ready", i_icb_cmd_ready,
              ~full & (hit ? o0_icb_cmd_ready : od_icb_cmd_ready));
        check("o0_addr", o0_icb_cmd_addr, i_icb_cmd_addr);
        check("od_addr", od_icb_cmd_addr, i_icb_cmd_addr);
        check("o0_read", o0_icb_cmd_read, i_icb_cmd_read);
        check("od_wdata", od_icb_cmd_wdata, i_icb_cmd_wdata);
        check("o0_wmask", o0_icb_cmd_wmask, i_icb_cmd_wmask);
        head = empty ? 1'b0 : ref_q[0].port;
        exp_rv = ~empty & (head ? od_icb_rsp_valid : o0_icb_rsp_valid);
        check("rsp_valid", i_icb_rsp_valid, exp_rv);
        check("o0_rsp_ready", o0_icb_rsp_ready, ~empty & ~head & i_icb_rsp_ready);
        check("od_rsp_ready", od_icb_rsp_ready, ~empty & head & i_icb_rsp_ready);
        if (exp_rv) begin
            check("rsp_err", i_icb_rsp_err, ref_q[0].err);
            check("rsp_rdata", i_icb_rsp_rdata, ref_q[0].rdata);
        end
        last_o0_cv = o0_icb_cmd_valid;
        last_od_cv = od_icb_cmd_valid;
        last_cmd_ready = i_icb_cmd_ready;
        last_rv = i_icb_rsp_valid;
        last_err = i_icb_rsp_err;
        last_rdata = i_icb_rsp_rdata;
        last_od_rr = od_icb_rsp_ready;
        if (i_icb_rsp_valid && i_icb_rsp_ready && ref_q.size() > 0) void'(ref_q.pop_front());
        if (o0_icb_rsp_valid && o0_icb_rsp_ready && s0_q.size() > 0) void'(s0_q.pop_front());
        if (od_icb_rsp_valid && od_icb_rsp_ready && sd_q.size() > 0) void'(sd_q.pop_front());
        if (i_icb_cmd_valid && i_icb_cmd_ready) begin
            e.port  = ~hit;
            e.err   = ~hit;
            e.rdata = hit ? o0_data(i_icb_cmd_addr) : od_data(i_icb_cmd_addr);
            ref_q.push_back(e);
        end
        if (o0_icb_cmd_valid && o0_icb_cmd_ready) s0_q.push_back(i_icb_cmd_addr);
        if (od_icb_cmd_valid && od_icb_cmd_ready) sd_q.push_back(i_icb_cmd_addr);
        @(posedge clk);
        #1;
        last_count = int'(dut.count);
        check("count", last_count, ref_q.size());
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (ref_q.size() > 0 && guard < 100) begin
            step(0, 100, 100, 100, 100, 100, 0, 32'h0, 1'b0);
            guard++;
        end
        check("drain_empty", ref_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_icb_cmd_valid = 1'b1; i_icb_cmd_addr = 32'h1000_0000; i_icb_cmd_read = 1'b1;
        i_icb_cmd_wdata = '0; i_icb_cmd_wmask = '0; i_icb_rsp_ready = 1'b1;
        o0_icb_cmd_ready = 1'b1; od_icb_cmd_ready = 1'b0;
        o0_icb_rsp_valid = 1'b1; o0_icb_rsp_err = 1'b0; o0_icb_rsp_rdata = '0;
        od_icb_rsp_valid = 1'b1; od_icb_rsp_err = 1'b1; od_icb_rsp_rdata = '0;
        #2;
        check("rst_rsp_valid", i_icb_rsp_valid, 1'b0);
        check("rst_o0_rsp_ready", o0_icb_rsp_ready, 1'b0);
        check("rst_od_rsp_ready", od_icb_rsp_ready, 1'b0);
        check("rst_cmd_ready", i_icb_cmd_ready, 1'b1);
        check("rst_o0_cmd_valid", o0_icb_cmd_valid, 1'b1);
        check("rst_count", dut.count, 0);
        i_icb_cmd_valid = 1'b0; o0_icb_rsp_valid = 1'b0; od_icb_rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Read hitting region 0
        step(100, 0, 100, 100, 0, 0, 3, 32'h1000_0004, 1'b1);
        check("rd_o0_cv", last_o0_cv, 1'b1);
        check("rd_od_cv", last_od_cv, 1'b0);
        step(0, 100, 100, 100, 100, 100, 0, 32'h0, 1'b0);
        check("rd_rv", last_rv, 1'b1);
        check("rd_rdata", last_rdata, 32'hDEAD_BEEF);
        check("rd_err", last_err, 1'b0);

        // Write missing every region
        step(100, 0, 100, 100, 0, 0, 3, 32'h2000_0000, 1'b0);
        check("miss_od_cv", last_od_cv, 1'b1);
        check("miss_o0_cv", last_o0_cv, 1'b0);
        step(0, 100, 100, 100, 100, 100, 0, 32'h0, 1'b0);
        check("miss_rv", last_rv, 1'b1);
        check("miss_err", last_err, 1'b1);

        // od answers before o0: held until o0 response returns
        step(100, 0, 100, 100, 0, 0, 3, 32'h1000_0010, 1'b1);
        step(100, 0, 100, 100, 0, 0, 3, 32'h3000_0000, 1'b1);
        step(0, 100, 100, 100, 0, 100, 0, 32'h0, 1'b0);
        check("ord_rv_held", last_rv, 1'b0);
        check("ord_od_rr_held", last_od_rr, 1'b0);
        step(0, 100, 100, 100, 100, 100, 0, 32'h0, 1'b0);
        check("ord_a_rv", last_rv, 1'b1);
        check("ord_a_rdata", last_rdata, 32'hDEAD_BEFB);
        check("ord_a_err", last_err, 1'b0);
        step(0, 100, 100, 100, 100, 100, 0, 32'h0, 1'b0);
        check("ord_b_rv", last_rv, 1'b1);
        check("ord_b_rdata", last_rdata, 32'hCFFF_FFFF);
        check("ord_b_err", last_err, 1'b1);

        // Full FIFO, then pop and new command in the same cycle
        step(100, 0, 100, 100, 0, 0, 1, 32'h0, 1'b0);
        step(100, 0, 100, 100, 0, 0, 1, 32'h0, 1'b0);
        check("full_count", last_count, 2);
        step(100, 0, 100, 100, 0, 0, 1, 32'h0, 1'b0);
        check("full_blocked", last_cmd_ready, 1'b0);
        step(100, 100, 100, 100, 100, 0, 1, 32'h0, 1'b0);
        check("full_pop_blocked", last_cmd_ready, 1'b0);
        check("full_pop_rv", last_rv, 1'b1);
        check("full_pop_count", last_count, 1);
        step(100, 0, 100, 100, 0, 0, 1, 32'h0, 1'b0);
        check("full_next_accept", last_cmd_ready, 1'b1);
        check("full_refill_count", last_count, 2);
        drain();

        // Reset with one command outstanding
        step(100, 0, 100, 100, 0, 0, 3, 32'h1000_0020, 1'b1);
        @(negedge clk);
        i_icb_cmd_valid = 1'b0;
        i_icb_rsp_ready = 1'b1;
        o0_icb_rsp_valid = 1'b1;
        o0_icb_rsp_rdata = o0_data(32'h1000_0020);
        #1;
        check("prerst_rv", i_icb_rsp_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_count", dut.count, 0);
        check("mrst_rv", i_icb_rsp_valid, 1'b0);
        check("mrst_o0_rr", o0_icb_rsp_ready, 1'b0);
        check("mrst_od_rr", od_icb_rsp_ready, 1'b0);
        i_icb_cmd_valid = 1'b1; i_icb_cmd_addr = 32'h1000_0040; o0_icb_cmd_ready = 1'b1;
        #1;
        check("mrst_cmd_ready", i_icb_cmd_ready, 1'b1);
        check("mrst_o0_cv", o0_icb_cmd_valid, 1'b1);
        i_icb_cmd_valid = 1'b0; o0_icb_rsp_valid = 1'b0;
        ref_q.delete(); s0_q.delete(); sd_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(100, 0, 100, 100, 0, 0, 3, 32'h1000_0004, 1'b1);
        step(0, 100, 100, 100, 100, 100, 0, 32'h0, 1'b0);
        check("postrst_rv", last_rv, 1'b1);
        check("postrst_rdata", last_rdata, 32'hDEAD_BEEF);

        // Randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            step(int'($urandom_range(20, 100)), int'($urandom_range(10, 100)),
                 int'($urandom_range(10, 100)), int'($urandom_range(10, 100)),
                 int'($urandom_range(10, 100)), int'($urandom_range(10, 100)),
                 0, 32'h0, 1'b0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
